logic_reduce_pipe: RTL and testbench
====================================

// Module: logic_reduce_pipe
// PURPOSE
//  Parametrised, pipelined N-operand bitwise logic unit for the Basic_Logic_Components library.
//  Successor to the single 2-input AND gate: it adds selectable mode, operand width, operand count,
//  configurable register stages and valid/ready flow control on both sides.
//  It sits between a streaming producer and consumer, and is the DUT for the next-generation inputs/outputs agents.
// PARAMETERS
//  WIDTH       8  bits per operand and result (1..64)
//  NUM_INPUTS  4  operands reduced per transaction (2..16)
//  STAGES      2  register stages from input handshake to output (1..4); fixed latency when unstalled
// PORTS
//  clk        in   1                 rising-edge clock, single domain
//  rst_n      in   1                 synchronous, active-low reset
//  in_valid   in   1                 operand set valid
//  in_ready   out  1                 block accepts operand set this cycle
//  in_data    in   NUM_INPUTS*WIDTH  operand k = in_data[k*WIDTH +: WIDTH]
//  in_mode    in   2                 logic_mode_t: 0 AND, 1 OR, 2 XOR, 3 NAND; sampled with in_data
//  out_valid  out  1                 result valid
//  out_ready  in   1                 consumer accepts result
//  out_data   out  WIDTH             bitwise reduction of the operands under the sampled mode
//  out_mode   out  2                 mode that produced out_data
// BEHAVIOUR
//  - Reset (clk edge with rst_n=0): every stage valid bit=0; out_valid=0; out_data=0; out_mode=0; in_ready=1 the cycle after.
//    Reset mid-stream discards all in-flight results; there is no partial-flush output.
//  - Handshake: transfer only when valid&&ready on the same edge. Once out_valid=1, out_data/out_mode hold until accepted.
//    out_valid does not depend combinationally on out_ready.
//  - Stage i holds {valid,mode,data}. Stage 0 computes the reduction; stages 1..STAGES-1 only move data.
//    ready_i = !valid_i || ready_{i+1}; ready_STAGES = out_ready; in_ready = ready_0.
//    Bubbles collapse: an empty stage loads even while a downstream stage is stalled.
//  - Latency: with out_ready held 1, a result appears exactly STAGES cycles after its input handshake.
//    Throughput is 1 per cycle.
//  - Ordering: strict FIFO. Capacity is STAGES transactions. in_ready=0 only when all stages are valid and out_ready=0.
//  - Arithmetic: AND = &ops, OR = |ops, XOR = ^ops, NAND = ~(&ops), bitwise per bit position. No carries, no width growth.
//  - Simultaneous events: a full pipe with out_ready=1 accepts a new input on the same edge the oldest result leaves.
//  - in_data and in_mode are don't-care when in_valid=0. Values that are X while in_valid=0 must not propagate.
// CONFIGURATION
//  - Macro LOGIC_REDUCE_PIPE_STATS_EN.
//  - Defined: extra output ports xfer_count[15:0] and stall_count[15:0], both reset to 0 and saturating at 16'hFFFF.
//    xfer_count increments per output handshake. stall_count increments per cycle with out_valid=1 and out_ready=0.
//  - Undefined: the ports and counters are absent; datapath behaviour and timing are identical.
// STRUCTURE
//  - Shared package logic_reduce_pkg holds typedef enum logic [1:0] logic_mode_t {LM_AND, LM_OR, LM_XOR, LM_NAND},
//    the constants MAX_WIDTH=64, MAX_INPUTS=16, MAX_STAGES=4, and the function reduce_ops(mode, ops).
//  - Sub-module logic_reduce_stage is one valid/ready register slice, parametrised on payload width.
//    It is instantiated STAGES times in a generate loop. Stage 0's input payload is {mode, reduce_ops(...)}.
//  - Elaboration asserts reject parameters out of range.
// TESTING
//  1. Reset, then idle -> out_valid=0, out_data=0, in_ready=1; stays so for 10 cycles with in_valid=0.
//  2. WIDTH=8, N=4, STAGES=2, out_ready=1; send AND {FF,F0,3C,FF} -> out_data=30 exactly 2 cycles later.
//     Then OR {01,02,04,08} -> 0F; XOR {FF,0F,00,00} -> F0; NAND {FF,FF,FF,FE} -> 01.
//  3. Back-to-back 100 random transactions, out_ready=1 -> one result per cycle, in order, matching the model.
//  4. out_ready=0 while sending 3 inputs, STAGES=2 -> first 2 accepted, in_ready=0 on the 3rd;
//     out_data holds its value; releasing out_ready drains results in order with none lost or duplicated.
//  5. Assert rst_n=0 for 1 cycle with 2 results in flight -> out_valid=0 next cycle; neither result ever appears.
//  6. With LOGIC_REDUCE_PIPE_STATS_EN: 5 transfers plus 7 stall cycles -> xfer_count=5, stall_count=7;
//     forcing 70000 stall cycles -> stall_count=FFFF.

Source files
------------

// File: rtl/logic_reduce_pkg.sv
// ============================================================================
// Module      : logic_reduce_pkg
// Description : Shared types, limits and the per-bit reduction function for
//               the logic_reduce_pipe family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_reduce_pkg;

    typedef enum logic [1:0] {
        LM_AND  = 2'd0,
        LM_OR   = 2'd1,
        LM_XOR  = 2'd2,
        LM_NAND = 2'd3
    } logic_mode_t;

    localparam int MAX_WIDTH  = 64;
    localparam int MAX_INPUTS = 16;
    localparam int MAX_STAGES = 4;

    // Reduces one bit column; only the first num_ops entries take part.
    function automatic logic reduce_ops(input logic_mode_t mode,
                                        input logic [MAX_INPUTS-1:0] ops,
                                        input int num_ops);
        logic w_and;
        logic w_or;
        logic w_xor;
        logic w_res;
        w_and = 1'b1;
        w_or  = 1'b0;
        w_xor = 1'b0;
        for (int k = 0; k < MAX_INPUTS; k++) begin
            if (k < num_ops) begin
                w_and = w_and & ops[k];
                w_or  = w_or  | ops[k];
                w_xor = w_xor ^ ops[k];
            end
        end
        case (mode)
            LM_AND:  w_res = w_and;
            LM_OR:   w_res = w_or;
            LM_XOR:  w_res = w_xor;
            LM_NAND: w_res = ~w_and;
            default: w_res = w_and;
        endcase
        return w_res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/logic_reduce_stage.sv
// ============================================================================
// Module      : logic_reduce_stage
// Description : One valid/ready register slice carrying an opaque payload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_reduce_stage #(
    parameter int PAYLOAD_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_data;

    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // Payload loads only with a valid beat so idle-bus garbage never enters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (in_ready) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data <= in_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/logic_reduce_pipe.sv
// ============================================================================
// Module      : logic_reduce_pipe
// Description : Pipelined N-operand bitwise AND/OR/XOR/NAND unit with
//               valid/ready flow control. Optional LOGIC_REDUCE_PIPE_STATS_EN
//               adds saturating transfer/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_reduce_pipe
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 4,
    parameter int STAGES     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [1:0]                  in_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [1:0]                  out_mode
`ifdef LOGIC_REDUCE_PIPE_STATS_EN
    ,
    output logic [15:0]                 xfer_count,
    output logic [15:0]                 stall_count
`endif
);

    localparam int c_payload_w = WIDTH + 2;

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("logic_reduce_pipe: WIDTH out of range");
    end
    if (NUM_INPUTS < 2 || NUM_INPUTS > MAX_INPUTS) begin : g_bad_inputs
        $error("logic_reduce_pipe: NUM_INPUTS out of range");
    end
    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("logic_reduce_pipe: STAGES out of range");
    end

    logic [WIDTH-1:0] w_result;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [MAX_INPUTS-1:0] w_column;
        for (genvar k = 0; k < MAX_INPUTS; k++) begin : g_op
            if (k < NUM_INPUTS) begin : g_used
                assign w_column[k] = in_data[k*WIDTH + b];
            end else begin : g_pad
                assign w_column[k] = 1'b0;
            end
        end
        assign w_result[b] = reduce_ops(logic_mode_t'(in_mode), w_column, NUM_INPUTS);
    end

    logic [STAGES-1:0]      w_valid;
    logic [STAGES-1:0]      w_dn_ready;
    logic [STAGES-1:0]      w_slot_ready;
    logic [c_payload_w-1:0] w_data [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic                   w_up_valid;
        logic [c_payload_w-1:0] w_up_data;

        if (i == 0) begin : g_head
            assign w_up_valid = in_valid;
            assign w_up_data  = {in_mode, w_result};
        end else begin : g_body
            assign w_up_valid = w_valid[i-1];
            assign w_up_data  = w_data[i-1];
            always_comb assert (w_slot_ready[i] == w_dn_ready[i-1]);
        end

        // Downstream readiness flattened: a later bubble or out_ready frees this slot.
        if (i == STAGES - 1) begin : g_tail
            assign w_dn_ready[i] = out_ready;
        end else begin : g_link
            assign w_dn_ready[i] = out_ready | ~(&w_valid[STAGES-1:i+1]);
        end

        logic_reduce_stage #(
            .PAYLOAD_W (c_payload_w)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (w_up_valid),
            .in_ready  (w_slot_ready[i]),
            .in_data   (w_up_data),
            .out_valid (w_valid[i]),
            .out_ready (w_dn_ready[i]),
            .out_data  (w_data[i])
        );
    end

    assign in_ready  = w_slot_ready[0];
    assign out_valid = w_valid[STAGES-1];
    assign out_data  = w_data[STAGES-1][WIDTH-1:0];
    assign out_mode  = w_data[STAGES-1][WIDTH +: 2];

`ifdef LOGIC_REDUCE_PIPE_STATS_EN
    logic [15:0] r_xfer_count;
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xfer_count  <= 16'd0;
            r_stall_count <= 16'd0;
        end else begin
            if (out_valid && out_ready && r_xfer_count != 16'hFFFF) begin
                r_xfer_count <= r_xfer_count + 16'd1;
            end
            if (out_valid && !out_ready && r_stall_count != 16'hFFFF) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign xfer_count  = r_xfer_count;
    assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_reduce_pipe.sv
// ============================================================================
// Module      : tb_logic_reduce_pipe
// Description : Scoreboard bench for logic_reduce_pipe (WIDTH=8, N=4, STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_reduce_pipe;

    localparam int WIDTH      = 8;
    localparam int NUM_INPUTS = 4;
    localparam int STAGES     = 2;
    localparam int DW         = NUM_INPUTS * WIDTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_mode;
`ifdef LOGIC_REDUCE_PIPE_STATS_EN
    logic [15:0]      xfer_count;
    logic [15:0]      stall_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH+1:0] exp_q [$];

    always #5 clk = ~clk;

    logic_reduce_pipe #(
        .WIDTH      (WIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .STAGES     (STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_mode    (out_mode)
`ifdef LOGIC_REDUCE_PIPE_STATS_EN
        ,
        .xfer_count  (xfer_count),
        .stall_count (stall_count)
`endif
    );

    function automatic logic [WIDTH-1:0] model(input logic [1:0] m, input logic [DW-1:0] d);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] o;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] op;
        a = '1;
        o = '0;
        x = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            op = d[k*WIDTH +: WIDTH];
            a  = a & op;
            o  = o | op;
            x  = x ^ op;
        end
        case (m)
            2'd0:    return a;
            2'd1:    return o;
            2'd2:    return x;
            default: return ~a;
        endcase
    endfunction

    // Output monitor: every output handshake is matched against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [WIDTH+1:0] exp;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected got mode=%0d data=%h required none", out_mode, out_data);
            end else begin
                exp = exp_q.pop_front();
                if ({out_mode, out_data} !== exp) begin
                    errors++;
                    $display("FAIL scoreboard_data got mode=%0d data=%h required mode=%0d data=%h",
                             out_mode, out_data, exp[WIDTH +: 2], exp[WIDTH-1:0]);
                end
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [DW-1:0] d,
                        input logic [WIDTH-1:0] exp, output int waited);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        waited   = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({m, exp});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_mode  = 'x;
                in_data  = 'x;
                return;
            end
            waited++;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout got in_ready=0 for 200 cycles required accept");
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 'x;
        in_data   = 'x;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || out_data !== '0 || out_mode !== 2'd0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle cycle %0d got v=%b d=%h m=%0d rdy=%b required v=0 d=00 m=0 rdy=1",
                         c, out_valid, out_data, out_mode, in_ready);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [1:0]       modes [4];
        logic [DW-1:0]    data  [4];
        logic [WIDTH-1:0] exps  [4];
        int               w;
        modes[0] = 2'd0; data[0] = 32'hFF3CF0FF; exps[0] = 8'h30;
        modes[1] = 2'd1; data[1] = 32'h08040201; exps[1] = 8'h0F;
        modes[2] = 2'd2; data[2] = 32'h00000FFF; exps[2] = 8'hF0;
        modes[3] = 2'd3; data[3] = 32'hFEFFFFFF; exps[3] = 8'h01;
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            send(modes[v], data[v], exps[v], w);
            for (int j = 0; j < STAGES - 1; j++) begin
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_early vec %0d got out_valid=%b required 0", v, out_valid);
                end
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL latency_exact vec %0d got out_valid=%b required 1", v, out_valid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int            w;
        int            total_wait;
        logic [1:0]    m;
        logic [DW-1:0] d;
        total_wait = 0;
        out_ready  = 1'b1;
        for (int n = 0; n < 100; n++) begin
            m = 2'($urandom_range(0, 3));
            d = DW'($urandom());
            send(m, d, model(m, d), w);
            total_wait += w;
        end
        checks++;
        if (total_wait != 0) begin
            errors++;
            $display("FAIL b2b_throughput got %0d wait cycles required 0", total_wait);
        end
        repeat (STAGES + 2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        int               w;
        logic [DW-1:0]    d;
        logic [WIDTH-1:0] head;
        out_ready = 1'b0;
        d = 32'h12345678; send(2'd2, d, model(2'd2, d), w);
        d = 32'hF0F0AAAA; send(2'd1, d, model(2'd1, d), w);
        head = exp_q[0][WIDTH-1:0];
        d = 32'hC3FF7EE7;
        in_valid = 1'b1;
        in_mode  = 2'd3;
        in_data  = d;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== head) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got rdy=%b v=%b d=%h required rdy=0 v=1 d=%h",
                         c, in_ready, out_valid, out_data, head);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pass_through got in_ready=%b required 1", in_ready);
        end else begin
            exp_q.push_back({2'd3, model(2'd3, d)});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = 'x;
        in_data  = 'x;
        repeat (STAGES + 3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_flush();
        int            w;
        int            seen;
        logic [DW-1:0] d;
        out_ready = 1'b0;
        d = 32'h0F0F0F0F; send(2'd0, d, model(2'd0, d), w);
        d = 32'h11223344; send(2'd2, d, model(2'd2, d), w);
        pulse_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_reset got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_ghost got %0d outputs required 0", seen);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef LOGIC_REDUCE_PIPE_STATS_EN
    task automatic test_stats();
        int            w;
        int            got;
        logic [DW-1:0] d;
        pulse_reset();
        @(negedge clk);
        checks++;
        if (xfer_count !== 16'd0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset got x=%h s=%h required 0 0", xfer_count, stall_count);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            d = DW'($urandom());
            send(2'd1, d, model(2'd1, d), w);
        end
        repeat (STAGES + 2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        d = 32'hDEADBEEF;
        send(2'd2, d, model(2'd2, d), w);
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        checks++;
        if (got == 0) begin
            errors++;
            $display("FAIL stats_wait got out_valid=0 required 1");
        end
        repeat (6) @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (xfer_count !== 16'd5 || stall_count !== 16'd7) begin
            errors++;
            $display("FAIL stats_count got x=%0d s=%0d required x=5 s=7", xfer_count, stall_count);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        d = 32'h01020304;
        send(2'd0, d, model(2'd0, d), w);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL stats_saturate got s=%h required FFFF", stall_count);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (STAGES + 2) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_flush();
`ifdef LOGIC_REDUCE_PIPE_STATS_EN
        test_stats();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
